// File: rtl/multicycle_controller.sv
// Control FSM for the shared multi-cycle RV32I datapath: sequences fetch, decode,
// execute, memory and write-back, and supervises memory waits with a timeout into TRAP.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OPcode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Sub,
  output logic       Fault,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_LUI, S_TRAP
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic [1:0] alu_op;
  logic       timeout;
  logic       unused_funct7;

  assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};
  assign state_dbg     = state;
  assign timeout       = (wait_cnt == TIMEOUT_CNT) && !MemReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    alu_op     = 2'b00;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    Fault      = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady)     state_next = S_DECODE;
        else if (timeout) state_next = S_TRAP;
      end
      S_DECODE: begin
        // PC-relative branch target is parked in ALUOut for BEQ.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (OPcode)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = S_EXECR;
          7'b0010011:             state_next = S_EXECI;
          7'b1100011:             state_next = S_BEQ;
          7'b1101111:             state_next = S_JAL;
          7'b0110111:             state_next = S_LUI;
          default:                state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = OPcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady)     state_next = S_MEMWB;
        else if (timeout) state_next = S_TRAP;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady)     state_next = S_FETCH;
        else if (timeout) state_next = S_TRAP;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b01;
        PCWrite    = Zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // Jump target from ALUOut goes to PC while the ALU forms the link value.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = 2'b11;
        ALUSrcB    = 2'b01;
        state_next = S_ALUWB;
      end
      S_TRAP: begin
        Fault = 1'b1;
      end
      default: state_next = S_TRAP;
    endcase
    wait_cnt_next = (MemReq && !MemReady && state_next == state) ? wait_cnt + 8'd1 : 8'd0;
  end

  always_comb begin
    ALUControl = 3'b000;
    Sub        = 1'b0;
    case (alu_op)
      2'b01: Sub = 1'b1;
      2'b10: begin
        ALUControl = Funct3;
        Sub        = (Funct3 == 3'b000) && OPcode[5] && Funct7[5];
      end
      default: ;
    endcase
  end

  always_comb begin
    case (OPcode)
      7'b0100011: ImmSrc = 3'b001;
      7'b1100011: ImmSrc = 3'b010;
      7'b0110111: ImmSrc = 3'b011;
      7'b1101111: ImmSrc = 3'b100;
      default:    ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level driver, per-cycle expected
// control words in a scoreboard queue, and a negedge monitor that compares them.
module tb_multicycle_controller;
  localparam int TO = 15;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BEQ = 9,
                 P_JAL = 10, P_LUI = 11, P_TRAP = 12;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111, OP_SYS = 7'b1110011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] OPcode, Funct7;
  logic [2:0] Funct3;
  logic       Zero, MemReady;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Sub, Fault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic [3:0] state_dbg;

  logic [19:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;
  string       ph_name[13] = '{"FETCH", "DECODE", "MEMADR", "MEMREAD", "MEMWB", "MEMWRITE",
                               "EXECR", "EXECI", "ALUWB", "BEQ", "JAL", "LUI", "TRAP"};

  multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .OPcode(OPcode), .Funct3(Funct3), .Funct7(Funct7),
    .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Sub(Sub), .Fault(Fault), .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  // Reference: control word for one cycle of a given instruction step.
  function automatic logic [19:0] expect_vec(int ph, logic mr, logic zero);
    logic       mreq, mwr, adr, irw, pcw, rgw, sub, flt;
    logic [1:0] rs, a, b;
    logic [2:0] imm, ctl;
    {mreq, mwr, adr, irw, pcw, rgw, sub, flt} = '0;
    rs = 2'b00; a = 2'b00; b = 2'b00; ctl = 3'b000;
    case (OPcode)
      OP_SW:   imm = 3'b001;
      OP_BEQ:  imm = 3'b010;
      OP_LUI:  imm = 3'b011;
      OP_JAL:  imm = 3'b100;
      default: imm = 3'b000;
    endcase
    case (ph)
      P_FETCH:  begin mreq = 1; irw = mr; pcw = mr; rs = 2'b10; b = 2'b10; end
      P_DECODE: begin a = 2'b01; b = 2'b01; end
      P_MEMADR: begin a = 2'b10; b = 2'b01; end
      P_MEMRD:  begin mreq = 1; adr = 1; end
      P_MEMWB:  begin rs = 2'b01; rgw = 1; end
      P_MEMWR:  begin mreq = 1; mwr = 1; adr = 1; end
      P_EXECR:  begin a = 2'b10; ctl = Funct3; sub = (Funct3 == 3'b000) && (Funct7 == 7'b0100000); end
      P_EXECI:  begin a = 2'b10; b = 2'b01; ctl = Funct3; end
      P_ALUWB:  rgw = 1;
      P_BEQ:    begin a = 2'b10; sub = 1; pcw = zero; end
      P_JAL:    begin a = 2'b01; b = 2'b10; pcw = 1; end
      P_LUI:    begin a = 2'b11; b = 2'b01; end
      default:  flt = 1;
    endcase
    return {mreq, mwr, adr, irw, pcw, rgw, rs, a, b, imm, ctl, sub, flt};
  endfunction

  // driver tasks
  task automatic step(int ph, logic mr, logic zero);
    MemReady = mr;
    Zero     = zero;
    exp_q.push_back(expect_vec(ph, mr, zero));
    name_q.push_back(ph_name[ph]);
    @(posedge clk);
    #1;
  endtask

  task automatic rstep(int ph);
    step(ph, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    MemReady = 1'b0;
    exp_q.push_back(expect_vec(P_FETCH, 1'b0, Zero));
    name_q.push_back("RESET");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic mem_wait(int ph, int w, output bit trapped);
    trapped = 1'b0;
    for (int i = 0; i < w && i <= TO; i++) step(ph, 1'b0, 1'($urandom_range(0, 1)));
    if (w > TO) begin
      trapped = 1'b1;
      for (int i = 0; i < 3; i++) rstep(P_TRAP);
    end else begin
      step(ph, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic zero,
                           int fw, int mw);
    bit tr;
    OPcode = op; Funct3 = f3; Funct7 = f7;
    mem_wait(P_FETCH, fw, tr);
    if (!tr) begin
      rstep(P_DECODE);
      case (op)
        OP_LW:  begin rstep(P_MEMADR); mem_wait(P_MEMRD, mw, tr); if (!tr) rstep(P_MEMWB); end
        OP_SW:  begin rstep(P_MEMADR); mem_wait(P_MEMWR, mw, tr); end
        OP_R:   begin rstep(P_EXECR); rstep(P_ALUWB); end
        OP_I:   begin rstep(P_EXECI); rstep(P_ALUWB); end
        OP_BEQ: step(P_BEQ, 1'($urandom_range(0, 1)), zero);
        OP_JAL: begin rstep(P_JAL); rstep(P_ALUWB); end
        OP_LUI: begin rstep(P_LUI); rstep(P_ALUWB); end
        default: begin
          tr = 1'b1;
          for (int i = 0; i < 3; i++) rstep(P_TRAP);
        end
      endcase
    end
    if (tr) do_reset();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [19:0] act, e;
    string       nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, ALUControl, Sub, Fault};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %05h expected %05h (op=%b f3=%b f7=%b MemReady=%b Zero=%b) t=%0t",
                 nm, act, e, OPcode, Funct3, Funct7, MemReady, Zero, $time);
      end
    end
  end

  initial begin
    logic [6:0] ops[8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    reset = 1'b1; OPcode = 7'd0; Funct3 = 3'd0; Funct7 = 7'd0; Zero = 1'b0; MemReady = 1'b0;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI, OP_SYS};
    @(posedge clk);
    #1;
    do_reset();

    run_instr(OP_R,   3'b000, 7'b0000000, 1'b0, 0, 0);    // add
    run_instr(OP_R,   3'b000, 7'b0100000, 1'b0, 0, 0);    // sub
    run_instr(OP_R,   3'b101, 7'b0100000, 1'b0, 1, 0);    // sra: no Sub
    run_instr(OP_I,   3'b000, 7'b0100000, 1'b0, 0, 0);    // addi, Funct7 bits ignored
    run_instr(OP_LW,  3'b010, 7'b0000000, 1'b0, 0, 3);
    run_instr(OP_SW,  3'b010, 7'b0000000, 1'b0, 2, 2);
    run_instr(OP_BEQ, 3'b000, 7'b0000000, 1'b1, 0, 0);
    run_instr(OP_BEQ, 3'b000, 7'b0000000, 1'b0, 0, 0);
    run_instr(OP_JAL, 3'b000, 7'b0000000, 1'b0, 0, 0);
    run_instr(OP_LUI, 3'b000, 7'b0000000, 1'b0, 0, 0);
    run_instr(OP_SYS, 3'b000, 7'b0000000, 1'b0, 0, 0);    // illegal -> TRAP
    run_instr(OP_R,   3'b000, 7'b0000000, 1'b0, TO, 0);   // ready on the last allowed cycle
    run_instr(OP_LW,  3'b010, 7'b0000000, 1'b0, 0, TO);
    run_instr(OP_R,   3'b000, 7'b0000000, 1'b0, TO + 1, 0); // fetch timeout
    run_instr(OP_LW,  3'b010, 7'b0000000, 1'b0, 0, TO + 1); // read timeout
    run_instr(OP_SW,  3'b010, 7'b0000000, 1'b0, 0, TO + 1); // write timeout

    // asynchronous reset in the middle of a held store strobe
    OPcode = OP_SW; Funct3 = 3'b010; Funct7 = 7'd0;
    step(P_FETCH, 1'b1, 1'b0);
    rstep(P_DECODE);
    rstep(P_MEMADR);
    step(P_MEMWR, 1'b0, 1'b0);
    step(P_MEMWR, 1'b0, 1'b0);
    do_reset();
    run_instr(OP_R, 3'b111, 7'b0000000, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      f3 = 3'($urandom_range(0, 7));
      f7 = (op == OP_R) ? (($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000)
                        : 7'($urandom_range(0, 127));
      run_instr(op, f3, f7, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
